// File: rtl/cpu_mmu_cpn_writer.sv
// Writes captured PPN_23_10 as a CPN tag (plus valid bit) into the cache tag RAM, or sweeps every index invalid.
// Every output is a register loaded from the next-state decode, so each output reflects the state it belongs to.
module cpu_mmu_cpn_writer #(
  parameter int IDX_W     = 8,
  parameter int WE_CYCLES = 2
) (
  input  logic             i_sysclk,
  input  logic             i_sys_rst_n,
  input  logic [13:0]      i_ppn_23_10,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_wr_req,
  input  logic             i_inv_all,
  output logic [13:0]      o_cpn_23_10,
  output logic             o_cvalid,
  output logic [IDX_W-1:0] o_caddr,
  output logic             o_cwe_n,
  output logic             o_wca_n,
  output logic             o_busy,
  output logic             o_ack
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

  state_t           r_state, w_state_n;
  logic [13:0]      r_cpn, w_cpn_n;
  logic             r_cvalid, w_cvalid_n;
  logic [IDX_W-1:0] r_caddr, w_caddr_n;
  logic             r_cwe_n, w_cwe_n_n;
  logic             r_wca_n, w_wca_n_n;
  logic             r_busy, w_busy_n;
  logic             r_ack, w_ack_n;
  logic [3:0]       r_we_cnt, w_we_cnt_n;
  logic             r_sweep, w_sweep_n;
  logic             w_last_idx;

  assign w_last_idx = &r_caddr;

  always_comb begin
    w_state_n  = r_state;
    w_cpn_n    = r_cpn;
    w_cvalid_n = r_cvalid;
    w_caddr_n  = r_caddr;
    w_we_cnt_n = r_we_cnt;
    w_sweep_n  = r_sweep;
    w_ack_n    = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_inv_all) begin
          w_cpn_n    = 14'h0;
          w_cvalid_n = 1'b0;
          w_caddr_n  = '0;
          w_sweep_n  = 1'b1;
          w_state_n  = SETUP;
        end else if (i_wr_req) begin
          w_cpn_n    = i_ppn_23_10;
          w_cvalid_n = 1'b1;
          w_caddr_n  = i_idx;
          w_sweep_n  = 1'b0;
          w_state_n  = SETUP;
        end
      end
      SETUP: begin
        w_we_cnt_n = WE_LOAD;
        w_state_n  = WRITE;
      end
      WRITE: begin
        // ACK is decided here so that it is registered into the HOLD cycle.
        if (r_we_cnt == 4'd0) begin
          w_state_n = HOLD;
          w_ack_n   = !r_sweep || w_last_idx;
        end else begin
          w_we_cnt_n = r_we_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (r_sweep && !w_last_idx) begin
          w_caddr_n = r_caddr + IDX_W'(1);
          w_state_n = SETUP;
        end else begin
          w_sweep_n = 1'b0;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase

    // The bus is claimed for the whole transaction, which brackets every CWE_n low pulse.
    w_busy_n  = (w_state_n != IDLE);
    w_wca_n_n = (w_state_n != IDLE);
    w_cwe_n_n = (w_state_n != WRITE);
  end

  always_ff @(posedge i_sysclk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state  <= IDLE;
      r_cpn    <= 14'h0;
      r_cvalid <= 1'b0;
      r_caddr  <= '0;
      r_cwe_n  <= 1'b1;
      r_wca_n  <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_we_cnt <= 4'd0;
      r_sweep  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cpn    <= w_cpn_n;
      r_cvalid <= w_cvalid_n;
      r_caddr  <= w_caddr_n;
      r_cwe_n  <= w_cwe_n_n;
      r_wca_n  <= w_wca_n_n;
      r_busy   <= w_busy_n;
      r_ack    <= w_ack_n;
      r_we_cnt <= w_we_cnt_n;
      r_sweep  <= w_sweep_n;
    end
  end

  assign o_cpn_23_10 = r_cpn;
  assign o_cvalid    = r_cvalid;
  assign o_caddr     = r_caddr;
  assign o_cwe_n     = r_cwe_n;
  assign o_wca_n     = r_wca_n;
  assign o_busy      = r_busy;
  assign o_ack       = r_ack;

endmodule

// File: tb/tb_cpu_mmu_cpn_writer.sv
// Bench for cpu_mmu_cpn_writer: an 8-bit-index instance and a 3-bit-index instance, each with its own
// expected-timeline model, plus directed scenarios with hand-computed expectations.
module tb_cpu_mmu_cpn_writer;

  localparam int WE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][13:0] ppn;
  logic [1:0][7:0]  idx;
  logic [1:0]       wr_req;
  logic [1:0]       inv_all;

  wire [1:0][13:0] cpn;
  wire [1:0]       cvalid;
  wire [1:0][7:0]  caddr;
  wire [1:0]       cwe_n;
  wire [1:0]       wca_n;
  wire [1:0]       busy;
  wire [1:0]       ack;
  wire [2:0]       caddr3;

  assign caddr[1] = {5'b0, caddr3};

  cpu_mmu_cpn_writer #(.IDX_W(8), .WE_CYCLES(WE)) u_dut8 (
    .i_sysclk(clk), .i_sys_rst_n(rst_n),
    .i_ppn_23_10(ppn[0]), .i_idx(idx[0]), .i_wr_req(wr_req[0]), .i_inv_all(inv_all[0]),
    .o_cpn_23_10(cpn[0]), .o_cvalid(cvalid[0]), .o_caddr(caddr[0]),
    .o_cwe_n(cwe_n[0]), .o_wca_n(wca_n[0]), .o_busy(busy[0]), .o_ack(ack[0])
  );

  cpu_mmu_cpn_writer #(.IDX_W(3), .WE_CYCLES(WE)) u_dut3 (
    .i_sysclk(clk), .i_sys_rst_n(rst_n),
    .i_ppn_23_10(ppn[1]), .i_idx(idx[1][2:0]), .i_wr_req(wr_req[1]), .i_inv_all(inv_all[1]),
    .o_cpn_23_10(cpn[1]), .o_cvalid(cvalid[1]), .o_caddr(caddr3),
    .o_cwe_n(cwe_n[1]), .o_wca_n(wca_n[1]), .o_busy(busy[1]), .o_ack(ack[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  typedef struct packed {
    logic [13:0] cpn;
    logic        cvalid;
    logic [7:0]  caddr;
    logic        cwe_n;
    logic        wca_n;
    logic        busy;
    logic        ack;
  } rec_t;

  // Each model expands an accepted request into the per-cycle output timeline the block must show.
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    localparam int IW = (g == 0) ? 8 : 3;
    localparam logic [7:0] LAST = 8'((1 << IW) - 1);

    rec_t        q[$];
    rec_t        cur, got;
    logic [13:0] m_cpn;
    logic        m_cvalid;
    logic [7:0]  m_caddr;
    logic        prev_ack;

    function automatic rec_t mk(input logic [13:0] c, input logic v, input logic [7:0] a,
                                input logic we_n, input logic own, input logic k);
      rec_t r;
      r.cpn = c; r.cvalid = v; r.caddr = a;
      r.cwe_n = we_n; r.wca_n = own; r.busy = own; r.ack = k;
      return r;
    endfunction

    task automatic push_entry(input logic [13:0] c, input logic v, input logic [7:0] a, input logic k);
      q.push_back(mk(c, v, a, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < WE; i++) q.push_back(mk(c, v, a, 1'b0, 1'b1, 1'b0));
      q.push_back(mk(c, v, a, 1'b1, 1'b1, k));
    endtask

    always @(posedge clk) begin
      if (!rst_n) begin
        q.delete();
        m_cpn = 14'h0; m_cvalid = 1'b0; m_caddr = 8'h0; prev_ack = 1'b0;
      end else begin
        if (q.size() == 0) begin
          if (inv_all[g]) begin
            m_cpn = 14'h0; m_cvalid = 1'b0;
            for (int i = 0; i <= int'(LAST); i++) push_entry(14'h0, 1'b0, 8'(i), i == int'(LAST));
            m_caddr = LAST;
            q.push_back(mk(m_cpn, m_cvalid, m_caddr, 1'b1, 1'b0, 1'b0));
          end else if (wr_req[g]) begin
            m_cpn = ppn[g]; m_cvalid = 1'b1; m_caddr = idx[g] & LAST;
            push_entry(m_cpn, m_cvalid, m_caddr, 1'b1);
            q.push_back(mk(m_cpn, m_cvalid, m_caddr, 1'b1, 1'b0, 1'b0));
          end
        end
        if (q.size() != 0) cur = q.pop_front();
        else cur = mk(m_cpn, m_cvalid, m_caddr, 1'b1, 1'b0, 1'b0);
        #1;
        got = mk(cpn[g], cvalid[g], caddr[g], cwe_n[g], wca_n[g], ack[g]);
        got.busy = busy[g];
        check($sformatf("dut%0d cycle outputs", g), 32'(got), 32'(cur));
        check($sformatf("dut%0d cwe_low_implies_wca_high", g), 32'(cwe_n[g] | wca_n[g]), 32'd1);
        check($sformatf("dut%0d ack_not_back_to_back", g), 32'(!(prev_ack && ack[g])), 32'd1);
        prev_ack = ack[g];
      end
    end
  end

  // Steps negedges until ACK on instance d, collecting what a tag-RAM observer would see.
  task automatic watch(input int d, input int budget, input int mod_at, input logic drop_wr,
                       input logic sweep, input logic [13:0] exp_cpn, input logic exp_v,
                       input logic [7:0] exp_addr,
                       output int ack_at, output int cwe_lo, output int busy_cyc,
                       output int wr_cnt, output logic data_ok);
    logic prev_we_n;
    prev_we_n = 1'b1;
    ack_at = 0; cwe_lo = 0; busy_cyc = 0; wr_cnt = 0; data_ok = 1'b1;
    for (int k = 1; k <= budget && ack_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) inv_all[d] = 1'b0;
      if (k == mod_at) begin ppn[d] = 14'h0001; idx[d] = 8'h7F; end
      if (busy[d]) busy_cyc++;
      if (!cwe_n[d]) begin
        cwe_lo++;
        if (cpn[d] !== exp_cpn || cvalid[d] !== exp_v) data_ok = 1'b0;
        if (prev_we_n) begin
          if (caddr[d] !== (sweep ? 8'(wr_cnt) : exp_addr)) data_ok = 1'b0;
          wr_cnt++;
        end
      end
      prev_we_n = cwe_n[d];
      if (ack[d]) begin
        ack_at = k;
        if (drop_wr) wr_req[d] = 1'b0;
      end
    end
  endtask

  int   ack_at, cwe_lo, busy_cyc, wr_cnt;
  logic data_ok;

  initial begin
    wr_req = '0; inv_all = '0; ppn = '0; idx = '0;
    repeat (2) @(negedge clk);
    check("reset cwe_n", 32'(cwe_n), 32'h3);
    check("reset wca_n", 32'(wca_n), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset ack", 32'(ack), 32'h0);
    check("reset cpn/cvalid/caddr", {cpn[0], cvalid[0], caddr[0]}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write; PPN/IDX disturbed during the first WRITE cycle.
    ppn[0] = 14'h2A5C; idx[0] = 8'h13; wr_req[0] = 1'b1;
    watch(0, 20, 2, 1'b1, 1'b0, 14'h2A5C, 1'b1, 8'h13, ack_at, cwe_lo, busy_cyc, wr_cnt, data_ok);
    check("write ack latency", 32'(ack_at), 32'd4);
    check("write cwe low cycles", 32'(cwe_lo), 32'd2);
    check("write busy cycles", 32'(busy_cyc), 32'd4);
    check("write count", 32'(wr_cnt), 32'd1);
    check("write tag 2A5C at 13", 32'(data_ok), 32'd1);
    check("hold cpn", 32'(cpn[0]), 32'h2A5C);
    @(negedge clk);
    check("idle after write busy", 32'(busy[0]), 32'd0);
    check("idle keeps caddr", 32'(caddr[0]), 32'h13);

    // Invalidate-all sweep on the 3-bit instance.
    repeat (2) @(negedge clk);
    inv_all[1] = 1'b1;
    watch(1, 100, 0, 1'b1, 1'b1, 14'h0, 1'b0, 8'h0, ack_at, cwe_lo, busy_cyc, wr_cnt, data_ok);
    check("sweep ack latency", 32'(ack_at), 32'd32);
    check("sweep busy cycles", 32'(busy_cyc), 32'd32);
    check("sweep writes", 32'(wr_cnt), 32'd8);
    check("sweep cwe low cycles", 32'(cwe_lo), 32'd16);
    check("sweep addr 0..7 cvalid0 cpn0", 32'(data_ok), 32'd1);
    @(negedge clk);
    check("sweep ends idle", 32'(busy[1]), 32'd0);
    check("sweep final caddr", 32'(caddr[1]), 32'h7);

    // Both requests together: sweep wins, held WR_REQ runs right after.
    repeat (2) @(negedge clk);
    ppn[1] = 14'h1234; idx[1] = 8'h05; wr_req[1] = 1'b1; inv_all[1] = 1'b1;
    watch(1, 100, 0, 1'b0, 1'b1, 14'h0, 1'b0, 8'h0, ack_at, cwe_lo, busy_cyc, wr_cnt, data_ok);
    check("priority sweep ack", 32'(ack_at), 32'd32);
    check("priority sweep writes", 32'(wr_cnt), 32'd8);
    watch(1, 20, 0, 1'b1, 1'b0, 14'h1234, 1'b1, 8'h05, ack_at, cwe_lo, busy_cyc, wr_cnt, data_ok);
    check("follow-on write ack", 32'(ack_at), 32'd5);
    check("follow-on write count", 32'(wr_cnt), 32'd1);
    check("follow-on write data", 32'(data_ok), 32'd1);

    // Asynchronous reset in the second WRITE cycle.
    repeat (2) @(negedge clk);
    ppn[0] = 14'h3FFF; idx[0] = 8'hAA; wr_req[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("second write cycle cwe_n", 32'(cwe_n[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async rst cwe_n", 32'(cwe_n[0]), 32'd1);
    check("async rst wca_n", 32'(wca_n[0]), 32'd0);
    check("async rst busy", 32'(busy[0]), 32'd0);
    check("async rst cpn/caddr", {cpn[0], caddr[0]}, 32'h0);
    wr_req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Recovery write at the top index.
    ppn[0] = 14'h0ABC; idx[0] = 8'hFF; wr_req[0] = 1'b1;
    watch(0, 20, 0, 1'b1, 1'b0, 14'h0ABC, 1'b1, 8'hFF, ack_at, cwe_lo, busy_cyc, wr_cnt, data_ok);
    check("recovery write ack", 32'(ack_at), 32'd4);
    check("recovery write data", 32'(data_ok), 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
